// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: turns per-stage stall/flush requests into
// per-stage stall and flush enables. A flush younger than an active stall is
// parked as a pending flush and fires once the stall no longer blocks it.
// Dropped stall requests may be stretched by MIN_HOLD cycles. Saturating
// activity counters and a sticky stall-timeout flag are kept alongside.
module pipe_hazard_ctrl #(
   parameter int NUM_STAGES = 6,
   parameter int MIN_HOLD   = 0,
   parameter int CNT_W      = 32,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  clr_in,
   input  logic [NUM_STAGES-1:0] stall_req_in,
   input  logic [NUM_STAGES-1:0] flush_req_in,
   output logic [NUM_STAGES-1:0] stall_out,
   output logic [NUM_STAGES-1:0] flush_out,
   output logic [CNT_W-1:0]      stall_cycles_out,
   output logic [CNT_W-1:0]      flush_count_out,
   output logic                  stall_timeout_out
);

   localparam int HOLD_W = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;

   typedef enum logic [1:0] {RUN, HOLD, PEND} state_t;

   state_t                state;
   // Indices are carried as prefix masks: mask(n) has bits 0..n set, so
   // "max of two indices" is an OR and "k > j" is a bit above mask(j).
   logic [NUM_STAGES-1:0] pendMask;
   logic [NUM_STAGES-1:0] holdMask;
   logic [HOLD_W-1:0]     holdCnt;
   logic [NUM_STAGES-1:0] rawMask;
   logic [NUM_STAGES-1:0] reqFlushMask;
   logic [NUM_STAGES-1:0] flushMask;
   logic [NUM_STAGES-1:0] stallComb;
   logic [NUM_STAGES-1:0] flushComb;
   logic                  stallHit;
   logic                  flushHit;
   logic                  holdActive;
   logic                  blockFlush;
   logic                  doFlush;
   logic                  stallNz;
   logic                  flushNz;
   logic [CNT_W-1:0]      stallCnt;
   logic [CNT_W-1:0]      flushCnt;

   // Request decode and priority resolution (zero-cycle path to outputs)
   always_comb begin
      logic accS;
      logic accF;
      accS         = 1'b0;
      accF         = 1'b0;
      rawMask      = '0;
      reqFlushMask = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         accS            = accS | stall_req_in[i];
         accF            = accF | flush_req_in[i];
         rawMask[i]      = accS;
         reqFlushMask[i] = accF;
      end
      // PC (bit 0) never issues a redirect
      reqFlushMask[0] = 1'b0;
      flushMask  = reqFlushMask | pendMask;
      stallHit   = rawMask[0];
      flushHit   = |flushMask;
      holdActive = (holdCnt != '0);
      // Stall from a stage older than the flush point wins; flush waits
      blockFlush = flushHit && (|(rawMask & ~(flushMask | NUM_STAGES'(1))));
      doFlush    = flushHit && !blockFlush;
      stallComb  = '0;
      flushComb  = '0;
      if (blockFlush)
         stallComb = rawMask;
      else if (doFlush)
         flushComb = flushMask;
      else
         stallComb = rawMask | (holdActive ? holdMask : '0);
      stallNz = |stallComb;
      flushNz = |flushComb;
   end

   assign stall_out        = rst_in ? stallComb : '0;
   assign flush_out        = rst_in ? flushComb : '0;
   assign stall_cycles_out = stallCnt;
   assign flush_count_out  = flushCnt;

   // FSM with pending-flush and hold-mask bookkeeping
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state    <= RUN;
         pendMask <= '0;
         holdMask <= '0;
         holdCnt  <= '0;
      end else if (doFlush) begin
         state    <= RUN;
         pendMask <= '0;
         holdMask <= '0;
         holdCnt  <= '0;
      end else begin
         if (blockFlush)
            pendMask <= flushMask;
         if (stallHit) begin
            holdMask <= (holdActive ? holdMask : '0) | rawMask;
            holdCnt  <= HOLD_W'(MIN_HOLD);
         end else if (holdActive) begin
            holdCnt  <= holdCnt - HOLD_W'(1);
         end
         if (blockFlush || state == PEND)
            state <= PEND;
         else if (stallHit ? (MIN_HOLD > 0) : (holdCnt > HOLD_W'(1)))
            state <= HOLD;
         else
            state <= RUN;
      end
   end

   // Saturating activity counters, clear beats increment
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else if (clr_in) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if (stallNz && stallCnt != '1)
            stallCnt <= stallCnt + CNT_W'(1);
         if (flushNz && flushCnt != '1)
            flushCnt <= flushCnt + CNT_W'(1);
      end
   end

   generate
      if (TIMEOUT > 0) begin : gTimeout
         localparam int TO_W = $clog2(TIMEOUT + 1);
         logic [TO_W-1:0] consec;
         logic            flag;

         // Consecutive-stall run length and sticky timeout flag
         always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
               consec <= '0;
               flag   <= 1'b0;
            end else if (clr_in) begin
               consec <= '0;
               flag   <= 1'b0;
            end else if (stallNz) begin
               if (consec != TO_W'(TIMEOUT))
                  consec <= consec + TO_W'(1);
               if (consec == TO_W'(TIMEOUT - 1))
                  flag <= 1'b1;
            end else begin
               consec <= '0;
            end
         end

         assign stall_timeout_out = flag;
      end else begin : gNoTimeout
         assign stall_timeout_out = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (no hold / 4-bit counters /
// timeout 8, and hold 2 / 32-bit counters / timeout off) share one directed
// stimulus. An index-based model is checked every cycle, and literal
// expectations pin the key scenarios.
module tb_pipe_hazard_ctrl;

   localparam int N   = 6;
   localparam int BIG = 1000;

   logic           clk = 1'b0;
   logic           rstN;
   logic           clr;
   logic [N-1:0]   sReq;
   logic [N-1:0]   fReq;
   logic [N-1:0]   sA, fA, sB, fB;
   logic [3:0]     scA, fcA;
   logic [31:0]    scB, fcB;
   logic           toA, toB;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int           pend;
      int           age;
      logic [N-1:0] ep;
      longint       sc;
      longint       fc;
      int           consec;
      bit           flag;
   } mst_t;

   mst_t mA, mB;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.NUM_STAGES(N), .MIN_HOLD(0), .CNT_W(4), .TIMEOUT(8)) dutA (
      .clk_in(clk), .rst_in(rstN), .clr_in(clr),
      .stall_req_in(sReq), .flush_req_in(fReq),
      .stall_out(sA), .flush_out(fA),
      .stall_cycles_out(scA), .flush_count_out(fcA),
      .stall_timeout_out(toA));

   pipe_hazard_ctrl #(.NUM_STAGES(N), .MIN_HOLD(2), .CNT_W(32), .TIMEOUT(0)) dutB (
      .clk_in(clk), .rst_in(rstN), .clr_in(clr),
      .stall_req_in(sReq), .flush_req_in(fReq),
      .stall_out(sB), .flush_out(fB),
      .stall_cycles_out(scB), .flush_count_out(fcB),
      .stall_timeout_out(toB));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [N-1:0] upTo(input int k);
      int m;
      m = (1 << (k + 1)) - 1;
      return m[N-1:0];
   endfunction

   function automatic int topBit(input logic [N-1:0] v, input int lo);
      int r;
      r = -1;
      for (int i = lo; i < N; i++)
         if (v[i]) r = i;
      return r;
   endfunction

   function automatic mst_t mreset();
      mst_t m;
      m.pend = 0; m.age = BIG; m.ep = '0; m.sc = 0; m.fc = 0; m.consec = 0; m.flag = 1'b0;
      return m;
   endfunction

   // One cycle of the controller rules, written with stage indices and ages
   task automatic modelStep(input mst_t s, input int minHold, input longint cntMax,
                            input int tmo, input logic [N-1:0] sr, input logic [N-1:0] fr,
                            input bit c, output logic [N-1:0] es, output logic [N-1:0] ef,
                            output mst_t ns);
      int k, j;
      bit holdVis, fires;
      ns = s;
      k  = topBit(sr, 0);
      j  = topBit(fr, 1);
      if (j < 0) j = 0;
      if (s.pend > j) j = s.pend;
      holdVis = (minHold > 0) && (s.age <= minHold);
      fires   = (j > 0) && (k <= j);
      es = '0;
      ef = '0;
      if (j > 0 && k > j) begin
         es = upTo(k);
         ns.pend = j;
      end else if (fires) begin
         ef = upTo(j) & ~N'(1);
         ns.pend = 0; ns.age = BIG; ns.ep = '0;
      end else begin
         if (k >= 0) es = upTo(k);
         if (holdVis) es = es | s.ep;
      end
      if (!fires) begin
         if (k >= 0) begin
            ns.ep  = (holdVis ? s.ep : '0) | upTo(k);
            ns.age = 1;
         end else if (ns.age < BIG) begin
            ns.age = ns.age + 1;
         end
      end
      if (c) begin
         ns.sc = 0; ns.fc = 0; ns.consec = 0; ns.flag = 1'b0;
      end else begin
         if (es != '0 && s.sc < cntMax) ns.sc = s.sc + 1;
         if (ef != '0 && s.fc < cntMax) ns.fc = s.fc + 1;
         if (es != '0) begin
            if (tmo > 0 && s.consec + 1 >= tmo) ns.flag = 1'b1;
            ns.consec = (s.consec + 1 > tmo) ? tmo : s.consec + 1;
         end else begin
            ns.consec = 0;
         end
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin : cmp
      logic [N-1:0] es, ef;
      mst_t nA, nB;
      if (!rstN) begin
         chk("rst.A.stall", sA, 0);  chk("rst.A.flush", fA, 0);
         chk("rst.A.scnt", scA, 0);  chk("rst.A.fcnt", fcA, 0);
         chk("rst.A.flag", toA, 0);
         chk("rst.B.stall", sB, 0);  chk("rst.B.flush", fB, 0);
         chk("rst.B.scnt", scB, 0);  chk("rst.B.fcnt", fcB, 0);
         mA = mreset();
         mB = mreset();
      end else begin
         chk("A.scnt", scA, mA.sc);
         chk("A.fcnt", fcA, mA.fc);
         chk("A.flag", toA, mA.flag);
         modelStep(mA, 0, 15, 8, sReq, fReq, clr, es, ef, nA);
         chk("A.stall", sA, es);
         chk("A.flush", fA, ef);
         mA = nA;
         chk("B.scnt", scB, mB.sc);
         chk("B.fcnt", fcB, mB.fc);
         chk("B.flag", toB, mB.flag);
         modelStep(mB, 2, 64'hFFFF_FFFF, 0, sReq, fReq, clr, es, ef, nB);
         chk("B.stall", sB, es);
         chk("B.flush", fB, ef);
         mB = nB;
      end
   end

   task automatic cyc(input logic [N-1:0] s, input logic [N-1:0] f);
      @(posedge clk);
      #1;
      sReq = s;
      fReq = f;
      #1;
   endtask

   initial begin
      rstN = 1'b0; clr = 1'b0; sReq = '0; fReq = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("lit.rst.stall", sA, 0);
      chk("lit.rst.scnt", scA, 0);
      rstN = 1'b1;

      // stall masks
      cyc(6'b000010, '0); chk("lit.stall1", sA, 6'b000011);
      cyc(6'b000100, '0); chk("lit.stall2", sA, 6'b000111);
      cyc(6'b010110, '0); chk("lit.stall4", sA, 6'b011111);
      repeat (3) cyc('0, '0);

      // plain flush
      cyc('0, 6'b001000);
      chk("lit.flush.f", fA, 6'b001110);
      chk("lit.flush.s", sA, 0);
      cyc('0, '0); chk("lit.flush.cnt", fcA, 1);

      // flush deferred behind an older stall
      cyc(6'b010000, 6'b001000); chk("lit.blk1.s", sA, 6'b011111); chk("lit.blk1.f", fA, 0);
      cyc(6'b010000, '0);        chk("lit.blk2.s", sA, 6'b011111); chk("lit.blk2.f", fA, 0);
      cyc(6'b010000, '0);        chk("lit.blk3.s", sA, 6'b011111); chk("lit.blk3.f", fA, 0);
      cyc('0, '0);               chk("lit.pend.f", fA, 6'b001110); chk("lit.pend.s", sA, 0);
      cyc('0, '0);               chk("lit.pend.done", fA, 0);

      // minimum hold on instance B
      cyc(6'b000100, '0); chk("lit.hold0", sB, 6'b000111);
      cyc('0, '0);        chk("lit.hold1", sB, 6'b000111); chk("lit.nohold", sA, 0);
      cyc('0, '0);        chk("lit.hold2", sB, 6'b000111);
      cyc('0, '0);        chk("lit.hold3", sB, 0);

      // timeout after 8 consecutive stall cycles
      for (int i = 0; i < 8; i++) begin
         cyc(6'b000001, '0);
         if (i == 7) chk("lit.to.before", toA, 0);
      end
      cyc('0, '0); chk("lit.to.set", toA, 1);
      cyc('0, '0); chk("lit.to.sticky", toA, 1);

      // synchronous clear
      clr = 1'b1;
      cyc('0, '0); clr = 1'b0;
      chk("lit.clr.flag", toA, 0);
      chk("lit.clr.scnt", scA, 0);
      chk("lit.clr.fcnt", fcA, 0);

      // counter saturation, then async reset mid-stall
      repeat (20) cyc(6'b000001, '0);
      cyc(6'b000001, '0);
      chk("lit.sat", scA, 15);
      chk("lit.sat.flag", toA, 1);
      #1 rstN = 1'b0;
      #1;
      chk("lit.arst.stall", sA, 0);
      chk("lit.arst.scnt", scA, 0);
      chk("lit.arst.flag", toA, 0);
      cyc('0, '0);
      @(posedge clk); #1 rstN = 1'b1;

      // reset drops a pending flush
      cyc(6'b010000, 6'b001000); chk("lit.rp.s", sA, 6'b011111);
      #1 rstN = 1'b0;
      cyc('0, '0);
      @(posedge clk); #1 rstN = 1'b1;
      cyc('0, '0); chk("lit.rp.dropped", fA, 0);

      // flush at the oldest stage kills a same-stage stall; bit 0 ignored
      cyc(6'b100000, 6'b100000); chk("lit.top.f", fA, 6'b111110); chk("lit.top.s", sA, 0);
      cyc('0, 6'b000001);        chk("lit.bit0.f", fA, 0);        chk("lit.bit0.s", sA, 0);

      // pending flushes merge by maximum index
      cyc(6'b100000, 6'b000100); chk("lit.mg1", sA, 6'b111111);
      cyc(6'b100000, 6'b001000); chk("lit.mg2", fA, 0);
      cyc(6'b100000, 6'b000010); chk("lit.mg3", fA, 0);
      cyc('0, '0);               chk("lit.mg.f", fA, 6'b001110);

      repeat (3) cyc('0, '0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
